// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared types and defaults for the register-file writeback arbiter
package rf_wb_arbiter_pkg;

  localparam int XLEN              = 32;
  localparam int RF_ARB_DEPTH      = 4;
  localparam int RF_ARB_STARVE_LIM = 8;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ll_wb_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - LL result queue with per-entry valid, kill-by-rd and match-by-rd
module rf_wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = RF_ARB_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     push_valid_i,
  input  ll_wb_t                   push_data_i,
  input  logic                     pop_i,
  input  logic                     kill_i,
  input  logic [4:0]               kill_rd_i,
  input  logic                     excl_head_i,
  input  logic [4:0]               match_a_rd_i,
  input  logic [4:0]               match_b_rd_i,
  output ll_wb_t                   head_o,
  output logic                     head_valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     match_a_o,
  output logic                     match_b_o
);

  localparam int PW = $clog2(DEPTH);

  ll_wb_t            mem [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [PW-1:0]     rd_ptr_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW:0]       count_q;

  // Next entry valids: WAW kill on resident entries, clear on pop, then the pushed slot
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_i && mem[i].rd == kill_rd_i) valid_d[i] = 1'b0;
    end
    if (pop_i)  valid_d[rd_ptr_q] = 1'b0;
    if (push_i) valid_d[wr_ptr_q] = push_valid_i;
  end

  // Pointers, occupancy and valids; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; the valid bits guard every read
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr_q] <= push_data_i;
  end

  // Pending lookup for decode, skipping the head when it is being written this cycle
  always_comb begin
    match_a_o = 1'b0;
    match_b_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !(excl_head_i && PW'(i) == rd_ptr_q)) begin
        if (match_a_rd_i != 5'd0 && mem[i].rd == match_a_rd_i) match_a_o = 1'b1;
        if (match_b_rd_i != 5'd0 && mem[i].rd == match_b_rd_i) match_b_o = 1'b1;
      end
    end
  end

  assign head_o       = mem[rd_ptr_q];
  assign head_valid_o = valid_q[rd_ptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - RF write-port arbiter between pipeline WB and LL unit; optional RF_ARB_STARVE_EN
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = RF_ARB_DEPTH
`ifdef RF_ARB_STARVE_EN
  , parameter int STARVE_LIM = RF_ARB_STARVE_LIM
`endif
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            pipe_we_i,
  input  logic [4:0]      pipe_rd_i,
  input  logic [XLEN-1:0] pipe_data_i,
  input  logic            ll_valid_i,
  output logic            ll_ready_o,
  input  logic [4:0]      ll_rd_i,
  input  logic [XLEN-1:0] ll_data_i,
  input  logic [4:0]      r1_addr_i,
  input  logic [4:0]      r2_addr_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            fwd_a_o,
  output logic            fwd_b_o,
  output logic            r1_pend_o,
  output logic            r2_pend_o,
  output logic            pipe_stall_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] count;
  ll_wb_t        head;
  ll_wb_t        push_data;
  logic          head_valid;
  logic          occupied;
  logic          stall;
  logic          grant_pipe;
  logic          grant_head;
  logic          bypass;
  logic          pop;
  logic          push;
  logic          push_valid;

  assign occupied   = (count != '0);
  assign ll_ready_o = (count < CW'(FIFO_DEPTH));
  assign push_data  = '{rd: ll_rd_i, data: ll_data_i};

  // Write-port grant: pipe, then queued head, then direct LL bypass into an empty queue
  always_comb begin
    grant_pipe = !stall && pipe_we_i;
    grant_head = !grant_pipe && occupied && head_valid;
    bypass     = !grant_pipe && !occupied && ll_valid_i;
    pop        = occupied && (grant_head || !head_valid);
    push       = ll_valid_i && ll_ready_o && !bypass;
    push_valid = !(grant_pipe && pipe_rd_i == ll_rd_i);
    rf_waddr_o = ll_rd_i;
    rf_wdata_o = ll_data_i;
    if (grant_pipe) begin
      rf_waddr_o = pipe_rd_i;
      rf_wdata_o = pipe_data_i;
    end else if (grant_head) begin
      rf_waddr_o = head.rd;
      rf_wdata_o = head.data;
    end
    rf_we_o = (grant_pipe || grant_head || bypass) && (rf_waddr_o != 5'd0);
  end

  assign fwd_a_o = rf_we_o && (rf_waddr_o == r1_addr_i) && (r1_addr_i != 5'd0);
  assign fwd_b_o = rf_we_o && (rf_waddr_o == r2_addr_i) && (r2_addr_i != 5'd0);

`ifdef RF_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [SW-1:0] starve_q;

  assign stall = occupied && head_valid && (starve_q == SW'(STARVE_LIM));

  // Count cycles a valid head is passed over; the limit forces one stalled pipe cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (pop) begin
      starve_q <= '0;
    end else if (occupied && head_valid && !grant_head && starve_q != SW'(STARVE_LIM)) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign stall = 1'b0;
`endif

  assign pipe_stall_o = stall;

  rf_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (push),
    .push_valid_i (push_valid),
    .push_data_i  (push_data),
    .pop_i        (pop),
    .kill_i       (grant_pipe),
    .kill_rd_i    (pipe_rd_i),
    .excl_head_i  (grant_head),
    .match_a_rd_i (r1_addr_i),
    .match_b_rd_i (r2_addr_i),
    .head_o       (head),
    .head_valid_o (head_valid),
    .count_o      (count),
    .match_a_o    (r1_pend_o),
    .match_b_o    (r2_pend_o)
  );

endmodule
